// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared constants for the multicycle MIPS-subset controller: opcodes,
// state encoding and datapath mux select encodings.
package ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_BLEZ  = 6'b000110;
   localparam logic [5:0] OP_BGTZ  = 6'b000111;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_R, S_WB_I, S_MEM_ADDR,
      S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_JAL, S_ILLEGAL
   } state_e;

   typedef enum logic [2:0] {PWC_NONE, PWC_BEQ, PWC_BNE, PWC_BLEZ, PWC_BGTZ} pcwcond_e;
   typedef enum logic [1:0] {SRCB_REGB, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SH2} srcb_e;
   typedef enum logic [1:0] {PSRC_ALU, PSRC_ALUOUT, PSRC_JUMP} psrc_e;
   typedef enum logic [1:0] {RD_RT, RD_RD, RD_R31} regdst_e;
   typedef enum logic [1:0] {M2R_ALUOUT, M2R_MDR, M2R_PC} memtoreg_e;

   // Branch opcodes 0001xx map onto the condition codes in order.
   function automatic pcwcond_e branch_cond(input logic [5:0] op);
      case (op[1:0])
         2'b00:   return PWC_BEQ;
         2'b01:   return PWC_BNE;
         2'b10:   return PWC_BLEZ;
         default: return PWC_BGTZ;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Controller <-> datapath bundle. illegal_op exists only when
// CTRL_ILLEGAL_TRAP_EN is defined.
interface multicycle_ctrl_fsm_if #(
   parameter int unsigned ALUOP_W = 4
);
   logic [5:0]         opCode;
   logic               mem_ready;
   logic [ALUOP_W-1:0] ALUOp;
   logic [2:0]         PCWriteCond;
   logic [1:0]         ALUSrcB;
   logic [1:0]         PCSource;
   logic [1:0]         RegDst;
   logic [1:0]         MemtoReg;
   logic               PCWrite;
   logic               IorD;
   logic               MemRead;
   logic               MemWrite;
   logic               IRWrite;
   logic               ALUSrcA;
   logic               RegWrite;
   logic               instr_done;
   logic               mem_timeout;
`ifdef CTRL_ILLEGAL_TRAP_EN
   logic               illegal_op;
`endif

   modport master (
      input  opCode, mem_ready,
      output ALUOp, PCWriteCond, ALUSrcB, PCSource, RegDst, MemtoReg, PCWrite,
             IorD, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite, instr_done,
             mem_timeout
`ifdef CTRL_ILLEGAL_TRAP_EN
      , output illegal_op
`endif
   );

   modport slave (
      output opCode, mem_ready,
      input  ALUOp, PCWriteCond, ALUSrcB, PCSource, RegDst, MemtoReg, PCWrite,
             IorD, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite, instr_done,
             mem_timeout
`ifdef CTRL_ILLEGAL_TRAP_EN
      , input illegal_op
`endif
   );

endinterface

// File: rtl/multicycle_ctrl_fsm_wait_timer.sv
// Memory wait counter: counts stalled cycles, flags the cycle on which the
// wait has lasted MEM_TIMEOUT cycles, and clears whenever no stall is pending.
module ctrl_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic waiting,
   input  logic ready,
   output logic expired
);
   localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // count_q holds completed stall cycles, so the MEM_TIMEOUT-th stall sees MEM_TIMEOUT-1
   always_comb begin
      expired = waiting && !ready && (cnt_q == CW'(MEM_TIMEOUT - 1));
      cnt_d   = '0;
      if (waiting && !ready && !expired) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS-subset control FSM. Outputs decode combinationally from the
// state (and mem_ready in wait states). Optional: CTRL_ILLEGAL_TRAP_EN.
module multicycle_ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int unsigned ALUOP_W     = 4,
   parameter int unsigned ALU_ADD     = 1,
   parameter int unsigned ALU_SUB     = 2,
   parameter int unsigned ALU_RTYPE   = 0,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   multicycle_ctrl_fsm_if.master   bus
);
   state_e state_q, state_d;
   logic   waiting, timeout;

   assign waiting = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

   ctrl_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk     (clk),
      .rst_n   (reset),
      .waiting (waiting),
      .ready   (bus.mem_ready),
      .expired (timeout)
   );

   always_comb begin
      state_d         = state_q;
      bus.ALUOp       = '0;
      bus.PCWriteCond = PWC_NONE;
      bus.ALUSrcB     = SRCB_REGB;
      bus.PCSource    = PSRC_ALU;
      bus.RegDst      = RD_RT;
      bus.MemtoReg    = M2R_ALUOUT;
      bus.PCWrite     = 1'b0;
      bus.IorD        = 1'b0;
      bus.MemRead     = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.ALUSrcA     = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.instr_done  = 1'b0;
      bus.mem_timeout = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      bus.illegal_op  = 1'b0;
`endif
      case (state_q)
         S_FETCH: begin
            bus.MemRead = 1'b1;
            bus.ALUSrcB = SRCB_FOUR;
            bus.ALUOp   = ALUOP_W'(ALU_ADD);
            if (bus.mem_ready) begin
               bus.IRWrite = 1'b1;
               bus.PCWrite = 1'b1;
               state_d     = S_DECODE;
            end
         end
         S_DECODE: begin
            bus.ALUSrcB = SRCB_IMM_SH2;
            bus.ALUOp   = ALUOP_W'(ALU_ADD);
            case (bus.opCode)
               OP_RTYPE:                         state_d = S_EXEC_R;
               OP_ADDI:                          state_d = S_EXEC_I;
               OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
               OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: state_d = S_BRANCH;
               OP_J:                             state_d = S_JUMP;
               OP_JAL:                           state_d = S_JAL;
               default:                          state_d = S_ILLEGAL;
            endcase
         end
         S_EXEC_R: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUOp   = ALUOP_W'(ALU_RTYPE);
            state_d     = S_WB_R;
         end
         S_EXEC_I: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = SRCB_IMM;
            bus.ALUOp   = ALUOP_W'(ALU_ADD);
            state_d     = S_WB_I;
         end
         S_WB_R, S_WB_I: begin
            bus.RegWrite   = 1'b1;
            bus.RegDst     = (state_q == S_WB_R) ? RD_RD : RD_RT;
            bus.instr_done = 1'b1;
            state_d        = S_FETCH;
         end
         S_MEM_ADDR: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = SRCB_IMM;
            bus.ALUOp   = ALUOP_W'(ALU_ADD);
            state_d     = (bus.opCode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            bus.IorD    = 1'b1;
            bus.MemRead = 1'b1;
            if (bus.mem_ready) state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            bus.RegWrite   = 1'b1;
            bus.MemtoReg   = M2R_MDR;
            bus.instr_done = 1'b1;
            state_d        = S_FETCH;
         end
         S_MEM_WR: begin
            bus.IorD     = 1'b1;
            bus.MemWrite = 1'b1;
            if (bus.mem_ready) begin
               bus.instr_done = 1'b1;
               state_d        = S_FETCH;
            end
         end
         S_BRANCH: begin
            bus.ALUSrcA     = 1'b1;
            bus.ALUOp       = ALUOP_W'(ALU_SUB);
            bus.PCSource    = PSRC_ALUOUT;
            bus.PCWriteCond = branch_cond(bus.opCode);
            bus.instr_done  = 1'b1;
            state_d         = S_FETCH;
         end
         S_JUMP: begin
            bus.PCWrite    = 1'b1;
            bus.PCSource   = PSRC_JUMP;
            bus.instr_done = 1'b1;
            state_d        = S_FETCH;
         end
         S_JAL: begin
            bus.RegWrite   = 1'b1;
            bus.RegDst     = RD_R31;
            bus.MemtoReg   = M2R_PC;
            bus.PCWrite    = 1'b1;
            bus.PCSource   = PSRC_JUMP;
            bus.instr_done = 1'b1;
            state_d        = S_FETCH;
         end
         default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            bus.illegal_op = 1'b1;
`else
            bus.instr_done = 1'b1;
            state_d        = S_FETCH;
`endif
         end
      endcase
      // An aborted wait commits nothing: the store strobe is withdrawn too.
      if (timeout) begin
         bus.mem_timeout = 1'b1;
         bus.MemWrite    = 1'b0;
         state_d         = S_FETCH;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: per-cycle expected control
// words come from an instruction-level model; honours CTRL_ILLEGAL_TRAP_EN.
module tb_multicycle_ctrl_fsm;
   localparam logic [3:0] A_ADD = 4'd1;
   localparam logic [3:0] A_SUB = 4'd2;
   localparam logic [3:0] A_RT  = 4'd0;
   localparam int unsigned TMO  = 4;

   typedef struct packed {
      logic [3:0] aluop;
      logic [2:0] pwc;
      logic [1:0] srcb, psrc, regdst, m2r;
      logic pcw, iord, mrd, mwr, irw, srca, rgw, done, tmo;
   } ctl_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   multicycle_ctrl_fsm_if #(.ALUOP_W(4)) bus ();

   multicycle_ctrl_fsm #(
      .ALUOP_W(4), .ALU_ADD(1), .ALU_SUB(2), .ALU_RTYPE(0), .MEM_TIMEOUT(TMO)
   ) dut (
      .clk   (clk),
      .reset (reset_n),
      .bus   (bus)
   );

   ctl_t dut_ctl;
   assign dut_ctl = {bus.ALUOp, bus.PCWriteCond, bus.ALUSrcB, bus.PCSource, bus.RegDst,
                     bus.MemtoReg, bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite,
                     bus.IRWrite, bus.ALUSrcA, bus.RegWrite, bus.instr_done, bus.mem_timeout};

   int checks = 0;
   int failures = 0;
   int done_seen = 0;
   ctl_t exp_q[$];
   bit rdy_q[$];
   logic [5:0] op_q[$];

   function automatic bit is_legal(input logic [5:0] op);
      return op inside {6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100,
                        6'b000101, 6'b000110, 6'b000111, 6'b000010, 6'b000011};
   endfunction

   function automatic ctl_t fetch_word(input bit ready);
      ctl_t c = '0;
      c.mrd = 1'b1; c.srcb = 2'b01; c.aluop = A_ADD;
      c.irw = ready; c.pcw = ready;
      return c;
   endfunction

   task automatic push(input ctl_t c, input bit r, input logic [5:0] op);
      exp_q.push_back(c); rdy_q.push_back(r); op_q.push_back(op);
   endtask

   task automatic gen_fetch(input logic [5:0] op, input int unsigned waits);
      for (int unsigned i = 0; i < waits; i++) push(fetch_word(1'b0), 1'b0, op);
      push(fetch_word(1'b1), 1'b1, op);
   endtask

   task automatic gen_fetch_timeout(input logic [5:0] op);
      ctl_t c;
      for (int unsigned i = 0; i + 1 < TMO; i++) push(fetch_word(1'b0), 1'b0, op);
      c = fetch_word(1'b0); c.tmo = 1'b1;
      push(c, 1'b0, op);
   endtask

   // Whole instruction; mw >= TMO means the data access times out.
   task automatic gen_instr(input logic [5:0] op, input int unsigned fw, input int unsigned mw);
      ctl_t c;
      gen_fetch(op, fw);
      c = '0; c.srcb = 2'b11; c.aluop = A_ADD;
      push(c, 1'($urandom), op);
      c = '0;
      case (op)
         6'b000000, 6'b001000: begin
            c.srca = 1'b1;
            c.srcb = (op == 6'b000000) ? 2'b00 : 2'b10;
            c.aluop = (op == 6'b000000) ? A_RT : A_ADD;
            push(c, 1'($urandom), op);
            c = '0; c.rgw = 1'b1; c.done = 1'b1;
            c.regdst = (op == 6'b000000) ? 2'b01 : 2'b00;
            push(c, 1'($urandom), op);
         end
         6'b100011, 6'b101011: begin
            c.srca = 1'b1; c.srcb = 2'b10; c.aluop = A_ADD;
            push(c, 1'($urandom), op);
            c = '0; c.iord = 1'b1;
            if (op == 6'b100011) c.mrd = 1'b1; else c.mwr = 1'b1;
            for (int unsigned i = 0; i < ((mw >= TMO) ? TMO - 1 : mw); i++) push(c, 1'b0, op);
            if (mw >= TMO) begin
               c.tmo = 1'b1; c.mwr = 1'b0;
               push(c, 1'b0, op);
            end else if (op == 6'b100011) begin
               push(c, 1'b1, op);
               c = '0; c.rgw = 1'b1; c.m2r = 2'b01; c.done = 1'b1;
               push(c, 1'($urandom), op);
            end else begin
               c.done = 1'b1;
               push(c, 1'b1, op);
            end
         end
         6'b000100, 6'b000101, 6'b000110, 6'b000111: begin
            c.srca = 1'b1; c.aluop = A_SUB; c.psrc = 2'b01; c.done = 1'b1;
            case (op)
               6'b000100: c.pwc = 3'b001;
               6'b000101: c.pwc = 3'b010;
               6'b000110: c.pwc = 3'b011;
               default:   c.pwc = 3'b100;
            endcase
            push(c, 1'($urandom), op);
         end
         6'b000010, 6'b000011: begin
            c.pcw = 1'b1; c.psrc = 2'b10; c.done = 1'b1;
            if (op == 6'b000011) begin
               c.rgw = 1'b1; c.regdst = 2'b10; c.m2r = 2'b10;
            end
            push(c, 1'($urandom), op);
         end
         default: begin
            c.done = 1'b1;
            push(c, 1'($urandom), op);
         end
      endcase
   endtask

   // Drives the queued cycles back to back; every cycle ends at posedge+1.
   task automatic run_queue(input string name);
      ctl_t e;
      int step = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         bus.mem_ready = rdy_q.pop_front();
         bus.opCode = op_q.pop_front();
         @(negedge clk);
         checks++;
         if (dut_ctl !== e) begin
            failures++;
            $display("FAIL %s step %0d: ctl got %h expected %h", name, step, dut_ctl, e);
         end
`ifdef CTRL_ILLEGAL_TRAP_EN
         checks++;
         if (bus.illegal_op !== 1'b0) begin
            failures++;
            $display("FAIL %s step %0d: illegal_op got %b expected 0", name, step, bus.illegal_op);
         end
`endif
         if (bus.instr_done === 1'b1) done_seen++;
         step++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      ctl_t e;
      reset_n = 1'b0; bus.mem_ready = 1'b0; bus.opCode = 6'b000000;
      @(negedge clk);
      e = fetch_word(1'b0);
      checks++;
      if (dut_ctl !== e) begin
         failures++;
         $display("FAIL reset_state: ctl got %h expected %h", dut_ctl, e);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   task automatic test_rtype;
      done_seen = 0;
      gen_instr(6'b000000, 0, 0);
      run_queue("rtype");
      checks++;
      if (done_seen !== 1) begin
         failures++;
         $display("FAIL rtype_done_count: got %0d expected 1", done_seen);
      end
   endtask

   task automatic test_lw_wait;
      gen_instr(6'b100011, 0, 3);
      run_queue("lw_wait");
   endtask

   task automatic test_branch_blez;
      gen_instr(6'b000110, 1, 0);
      run_queue("blez");
   endtask

   task automatic test_jal;
      gen_instr(6'b000011, 0, 0);
      run_queue("jal");
   endtask

   task automatic test_timeouts;
      gen_fetch_timeout(6'b000000);
      gen_instr(6'b001000, 0, 0);
      gen_instr(6'b100011, 0, TMO);
      gen_instr(6'b101011, 2, TMO);
      gen_instr(6'b101011, 3, 3);
      run_queue("timeouts");
   endtask

   task automatic test_latency;
      logic [5:0] ops[7] = '{6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000101, 6'b000010, 6'b000011};
      int lat[7] = '{4, 4, 5, 4, 3, 3, 3};
      int n;
      bit found;
      for (int i = 0; i < 7; i++) begin
         n = 0; found = 1'b0;
         while (!found && n < 20) begin
            bus.mem_ready = 1'b1; bus.opCode = ops[i];
            @(negedge clk);
            n++;
            if (bus.instr_done === 1'b1) found = 1'b1;
            @(posedge clk); #1;
         end
         checks++;
         if (!found || n != lat[i]) begin
            failures++;
            $display("FAIL latency op=%b: got %0d cycles (done seen %0b) expected %0d", ops[i], n, found, lat[i]);
         end
      end
   endtask

   task automatic test_reset_mid;
      ctl_t e;
      gen_fetch(6'b000000, 0);
      push('{aluop: A_ADD, srcb: 2'b11, default: '0}, 1'b1, 6'b000000);
      push('{aluop: A_RT, srca: 1'b1, default: '0}, 1'b1, 6'b000000);
      run_queue("reset_mid_pre");
      bus.mem_ready = 1'b0;
      #1;
      checks++;
      if (bus.RegWrite !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_wb: RegWrite got %b expected 1", bus.RegWrite);
      end
      reset_n = 1'b0;
      #1;
      e = fetch_word(1'b0);
      checks++;
      if (dut_ctl !== e) begin
         failures++;
         $display("FAIL reset_mid_abort: ctl got %h expected %h", dut_ctl, e);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      gen_instr(6'b000100, 0, 0);
      run_queue("reset_mid_post");
   endtask

   task automatic test_illegal;
`ifdef CTRL_ILLEGAL_TRAP_EN
      ctl_t e;
      gen_fetch(6'b111111, 0);
      push('{aluop: A_ADD, srcb: 2'b11, default: '0}, 1'b1, 6'b111111);
      run_queue("illegal_pre");
      for (int i = 0; i < 5; i++) begin
         bus.mem_ready = 1'($urandom); bus.opCode = 6'($urandom);
         @(negedge clk);
         checks++;
         if (bus.illegal_op !== 1'b1 || dut_ctl !== '0) begin
            failures++;
            $display("FAIL illegal_trap cycle %0d: illegal_op %b ctl %h expected 1 and 0", i, bus.illegal_op, dut_ctl);
         end
         @(posedge clk); #1;
      end
      reset_n = 1'b0; bus.mem_ready = 1'b0;
      #1;
      e = fetch_word(1'b0);
      checks++;
      if (bus.illegal_op !== 1'b0 || dut_ctl !== e) begin
         failures++;
         $display("FAIL illegal_release: illegal_op %b ctl %h expected 0 and %h", bus.illegal_op, dut_ctl, e);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
`else
      done_seen = 0;
      gen_instr(6'b111111, 0, 0);
      gen_instr(6'b000000, 0, 0);
      run_queue("illegal_nop");
      checks++;
      if (done_seen !== 2) begin
         failures++;
         $display("FAIL illegal_done_count: got %0d expected 2", done_seen);
      end
`endif
   endtask

   task automatic test_random;
      logic [6:0] legal[10] = '{7'h00, 7'h08, 7'h23, 7'h2b, 7'h04, 7'h05, 7'h06, 7'h07, 7'h02, 7'h03};
      logic [5:0] op;
      for (int n = 0; n < 60; n++) begin
         op = legal[$urandom_range(0, 9)][5:0];
`ifndef CTRL_ILLEGAL_TRAP_EN
         if ($urandom_range(0, 9) == 0) begin
            do op = 6'($urandom); while (is_legal(op));
         end
`endif
         if ($urandom_range(0, 7) == 0) gen_fetch_timeout(op);
         gen_instr(op, $urandom_range(0, TMO - 1), $urandom_range(0, TMO));
      end
      run_queue("random");
   endtask

   initial begin
      bus.mem_ready = 1'b0;
      bus.opCode = 6'b000000;
      @(posedge clk); #1;
      test_reset;
      test_rtype;
      test_lw_wait;
      test_branch_blez;
      test_jal;
      test_timeouts;
      test_latency;
      test_reset_mid;
      test_random;
      test_illegal;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
